// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin grant,
// registered broadcast of the winning (tag, data) plus a one-hot done pulse.
module cdb_arbiter #(
    parameter int unsigned       N_FU        = 4,
    parameter int unsigned       TAG_W       = 4,
    parameter logic [TAG_W-1:0]  INVALID_TAG = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    input  logic [N_FU-1:0]       fu_valid,
    input  logic [N_FU*TAG_W-1:0] fu_tag,
    input  logic [N_FU*32-1:0]    fu_data,
    output logic [N_FU-1:0]       fu_ready,
    output logic                  cdb_valid,
    output logic [TAG_W-1:0]      cdb_tag,
    output logic [31:0]           cdb_data,
    output logic [N_FU-1:0]       done,
    output logic                  err_invalid_tag
);

    localparam int unsigned RR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]  hv;
    logic [TAG_W-1:0] ht [N_FU];
    logic [31:0]      hd [N_FU];
    logic [RR_W-1:0]  rr;
    logic [RR_W-1:0]  win;
    logic [RR_W-1:0]  rr_next;
    logic [RR_W-1:0]  idx_w;
    logic             found;
    logic [N_FU-1:0]  grant;
    int unsigned      idx;

    // Scan from rr upward, wrapping modulo N_FU; first held slot wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_w = '0;
        for (int unsigned k = 0; k < N_FU; k++) begin
            idx   = (32'(rr) + k) % N_FU;
            idx_w = RR_W'(idx);
            if (!found && hv[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
        grant = '0;
        if (found) begin
            grant[win] = 1'b1;
        end
        rr_next = (32'(win) == N_FU - 1) ? '0 : win + 1'b1;
    end

    assign fu_ready = ~hv | grant;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hv              <= '0;
            rr              <= '0;
            cdb_valid       <= 1'b0;
            cdb_tag         <= INVALID_TAG;
            cdb_data        <= '0;
            done            <= '0;
            err_invalid_tag <= 1'b0;
            for (int unsigned i = 0; i < N_FU; i++) begin
                ht[i] <= INVALID_TAG;
                hd[i] <= '0;
            end
        end else if (flush) begin
            hv        <= '0;
            rr        <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= INVALID_TAG;
            cdb_data  <= '0;
            done      <= '0;
        end else begin
            if (found) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= ht[win];
                cdb_data  <= hd[win];
                done      <= grant;
                rr        <= rr_next;
                hv[win]   <= 1'b0;
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= INVALID_TAG;
                cdb_data  <= '0;
                done      <= '0;
            end
            // A capture on the granted port overrides the clear above, so the slot refills.
            for (int unsigned i = 0; i < N_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    if (fu_tag[i*TAG_W +: TAG_W] != INVALID_TAG) begin
                        hv[i] <= 1'b1;
                        ht[i] <= fu_tag[i*TAG_W +: TAG_W];
                        hd[i] <= fu_data[i*32 +: 32];
                    end else begin
                        err_invalid_tag <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-cycle comparison against a slot/pointer model plus
// directed scenarios with hand-computed broadcast sequences.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            flush = 1'b0;
    logic [N-1:0]    fu_valid = '0;
    logic [N*TW-1:0] fu_tag = '0;
    logic [N*32-1:0] fu_data = '0;
    logic [N-1:0]    fu_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [31:0]     cdb_data;
    logic [N-1:0]    done;
    logic            err_invalid_tag;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    logic [TW-1:0] seen[$];
    int exp_q[$];

    cdb_arbiter #(.N_FU(N), .TAG_W(TW), .INVALID_TAG(4'd0)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
        .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .done(done), .err_invalid_tag(err_invalid_tag)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0]  m_hv;
    logic [TW-1:0] m_ht [N];
    logic [31:0]   m_hd [N];
    int            m_rr;
    int            m_w;
    logic [N-1:0]  m_grant, m_ready;
    logic          exp_valid, exp_err;
    logic [TW-1:0] exp_tag;
    logic [31:0]   exp_data;
    logic [N-1:0]  exp_done;

    function automatic int pick(input logic [N-1:0] hv, input int rr);
        for (int k = 0; k < N; k++)
            if (hv[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    assign m_w     = pick(m_hv, m_rr);
    assign m_grant = (m_w >= 0) ? (N'(1) << m_w) : '0;
    assign m_ready = ~m_hv | m_grant;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_hv <= '0; m_rr <= 0; exp_valid <= 1'b0; exp_tag <= '0;
            exp_data <= '0; exp_done <= '0; exp_err <= 1'b0;
        end else if (flush) begin
            m_hv <= '0; m_rr <= 0; exp_valid <= 1'b0; exp_tag <= '0;
            exp_data <= '0; exp_done <= '0;
        end else begin
            if (m_w >= 0) begin
                exp_valid <= 1'b1; exp_tag <= m_ht[m_w]; exp_data <= m_hd[m_w];
                exp_done <= m_grant; m_rr <= (m_w + 1) % N; m_hv[m_w] <= 1'b0;
            end else begin
                exp_valid <= 1'b0; exp_tag <= '0; exp_data <= '0; exp_done <= '0;
            end
            for (int i = 0; i < N; i++) begin
                if (fu_valid[i] && m_ready[i]) begin
                    if (fu_tag[i*TW +: TW] != 0) begin
                        m_hv[i] <= 1'b1;
                        m_ht[i] <= fu_tag[i*TW +: TW];
                        m_hd[i] <= fu_data[i*32 +: 32];
                    end else begin
                        exp_err <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (started && !RST) begin
            check("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
            check("cdb_tag", 64'(cdb_tag), 64'(exp_tag));
            check("cdb_data", 64'(cdb_data), 64'(exp_data));
            check("done", 64'(done), 64'(exp_done));
            check("fu_ready", 64'(fu_ready), 64'(m_ready));
            check("err_invalid_tag", 64'(err_invalid_tag), 64'(exp_err));
            if (cdb_valid) seen.push_back(cdb_tag);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
    endtask

    task automatic set_fu(input int i, input logic [TW-1:0] tag, input logic [31:0] d);
        fu_valid[i]        = 1'b1;
        fu_tag[i*TW +: TW] = tag;
        fu_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        flush = 1'b0;
        RST = 1'b1;
        #1;
        check("rst_async_valid", 64'(cdb_valid), 64'd0);
        check("rst_async_done", 64'(done), 64'd0);
        tick();
        RST = 1'b0;
    endtask

    task automatic check_seen(input string name);
        check({name, "_count"}, 64'(seen.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < seen.size(); k++)
            check({name, "_tag"}, 64'(seen[k]), 64'(exp_q[k]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int next;
        bit acc;

        // reset then idle
        RST = 1'b1;
        tick();
        RST = 1'b0;
        started = 1'b1;
        repeat (5) begin
            tick();
            check("idle_valid", 64'(cdb_valid), 64'd0);
            check("idle_tag", 64'(cdb_tag), 64'd0);
            check("idle_done", 64'(done), 64'd0);
            check("idle_ready", 64'(fu_ready), 64'hF);
        end

        // single result
        seen.delete();
        set_fu(2, 4'd5, 32'hDEADBEEF);
        check("single_ready", 64'(fu_ready[2]), 64'd1);
        tick();
        clear_inputs();
        check("single_e0_valid", 64'(cdb_valid), 64'd0);
        tick();
        check("single_valid", 64'(cdb_valid), 64'd1);
        check("single_tag", 64'(cdb_tag), 64'd5);
        check("single_data", 64'(cdb_data), 64'hDEADBEEF);
        check("single_done", 64'(done), 64'b0100);
        tick();
        check("single_after_valid", 64'(cdb_valid), 64'd0);
        check("single_after_done", 64'(done), 64'd0);

        // contention: all four at once, rr starts at 0
        do_reset();
        for (int i = 0; i < N; i++) set_fu(i, 4'(i + 1), 32'(100 + i));
        tick();
        clear_inputs();
        for (int i = 0; i < N; i++) begin
            check("cont_ready", 64'(fu_ready), 64'((1 << (i + 1)) - 1));
            tick();
            check("cont_tag", 64'(cdb_tag), 64'(i + 1));
            check("cont_data", 64'(cdb_data), 64'(100 + i));
            check("cont_done", 64'(done), 64'(1 << i));
        end
        tick();
        check("cont_end_valid", 64'(cdb_valid), 64'd0);

        // round-robin fairness: FU0 streams 1..8, FU1 injects 9 at cycle 3
        do_reset();
        seen.delete();
        next = 1;
        for (int c = 0; c < 40 && next <= 8; c++) begin
            set_fu(0, 4'(next), 32'h1000 + 32'(next));
            if (c == 3) begin
                set_fu(1, 4'd9, 32'h9999);
                check("rr_fu1_ready", 64'(fu_ready[1]), 64'd1);
            end else begin
                fu_valid[1] = 1'b0;
            end
            acc = fu_ready[0];
            tick();
            if (acc) next++;
        end
        clear_inputs();
        check("rr_stream_done", 64'(next), 64'd9);
        repeat (4) tick();
        exp_q = '{1, 2, 3, 9, 4, 5, 6, 7, 8};
        check_seen("rr_order");

        // back-to-back streaming on FU3
        do_reset();
        for (int t = 6; t <= 8; t++) begin
            set_fu(3, 4'(t), 32'(t * 16));
            check("stream_ready", 64'(fu_ready[3]), 64'd1);
            tick();
            if (t > 6) begin
                check("stream_valid", 64'(cdb_valid), 64'd1);
                check("stream_tag", 64'(cdb_tag), 64'(t - 1));
            end
        end
        clear_inputs();
        tick();
        check("stream_last_tag", 64'(cdb_tag), 64'd8);
        check("stream_last_done", 64'(done), 64'b1000);
        tick();
        check("stream_end_valid", 64'(cdb_valid), 64'd0);

        // flush with held entries and rr moved away from 0
        do_reset();
        seen.delete();
        set_fu(2, 4'd7, 32'h77);
        tick();
        clear_inputs();
        set_fu(0, 4'd2, 32'h22);
        set_fu(1, 4'd3, 32'h33);
        tick();
        clear_inputs();
        flush = 1'b1;
        set_fu(2, 4'd8, 32'h88);
        tick();
        flush = 1'b0;
        clear_inputs();
        check("flush_valid", 64'(cdb_valid), 64'd0);
        check("flush_ready", 64'(fu_ready), 64'hF);
        tick();
        set_fu(1, 4'd11, 32'hB);
        set_fu(3, 4'd12, 32'hC);
        tick();
        clear_inputs();
        repeat (4) tick();
        exp_q = '{7, 11, 12};
        check_seen("flush_order");

        // invalid tag: discarded, sticky error survives flush, cleared by reset
        seen.delete();
        set_fu(1, 4'd0, 32'h55);
        tick();
        clear_inputs();
        check("inv_err", 64'(err_invalid_tag), 64'd1);
        repeat (3) tick();
        check("inv_no_bcast", 64'(seen.size()), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("inv_err_after_flush", 64'(err_invalid_tag), 64'd1);
        do_reset();
        check("inv_err_after_rst", 64'(err_invalid_tag), 64'd0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Downstream of the functional units, upstream of every reservation station.
- Collects completed results (tag, data) from N_FU functional units, holds one pending result per FU, and grants the common data bus (CDB) to one of them per cycle in round-robin order.
- The registered CDB broadcast drives cdb_in of all reservation stations.
- The one-hot done pulse releases the winning FU's reservation station.

Parameters:
- N_FU, 4, number of functional-unit result ports (2..8).
- TAG_W, 4, width of an RS tag.
- INVALID_TAG, 0, tag encoding meaning "no station / no broadcast".

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all pending and outgoing results.
- fu_valid  input  N_FU  per-FU result valid.
- fu_tag  input  N_FU*TAG_W  per-FU result tag (rd_tag of issuing station); port i occupies bits [i*TAG_W +: TAG_W].
- fu_data  input  N_FU*32  per-FU result value; port i occupies bits [i*32 +: 32].
- fu_ready  output  N_FU  per-FU accept (combinational).
- cdb_valid  output  1  broadcast valid (registered).
- cdb_tag  output  TAG_W  broadcast tag (registered); INVALID_TAG whenever cdb_valid=0.
- cdb_data  output  32  broadcast value (registered); 0 whenever cdb_valid=0.
- done  output  N_FU  one-hot, aligned with cdb_valid: the FU whose result is on the bus.
- err_invalid_tag  output  1  sticky flag: a result with tag INVALID_TAG was presented.

Behaviour:
- State per port i:
  - hv[i]: holding entry full.
  - ht[i], hd[i]: held tag and data.
  - rr: round-robin pointer, log2(N_FU) bits.
- Reset (async, RST=1):
  - hv=0, rr=0.
  - cdb_valid=0, cdb_tag=INVALID_TAG, cdb_data=0.
  - done=0, err_invalid_tag=0.
- Arbitration (combinational, each cycle):
  - Winner w = first i with hv[i]=1, scanning rr, rr+1, … modulo N_FU.
  - grant = onehot(w); grant=0 if no hv set.
- Ready:
  - fu_ready[i] = !hv[i] | grant[i].
  - An entry being broadcast this edge frees its slot the same edge, so an FU can stream one result every cycle when uncontended.
- Capture (rising edge, fu_valid[i] & fu_ready[i]):
  - Tag ≠ INVALID_TAG: hv[i]←1, ht[i]←fu_tag[i], hd[i]←fu_data[i].
  - Tag = INVALID_TAG: result is consumed and discarded, hv[i] unchanged from its cleared/grant value, err_invalid_tag←1.
- Broadcast (rising edge, grant≠0):
  - cdb_valid←1, cdb_tag←ht[w], cdb_data←hd[w], done←grant.
  - hv[w]←0 unless recaptured the same edge.
  - rr←(w+1) mod N_FU.
- If grant=0 on an edge: cdb_valid←0, cdb_tag←INVALID_TAG, cdb_data←0, done←0, rr unchanged.
- Latency: a handshake at edge E0 produces a result on the CDB during the cycle after edge E1 at the earliest (two edges). Each extra contending entry ahead of it adds one cycle.
- Throughput: at most one broadcast per cycle.
- Fairness: a pending entry is broadcast within N_FU cycles of becoming held.
- Simultaneous capture and grant on the same port: the old entry is broadcast and the new entry is held; no loss, no duplicate.
- A held entry never changes until granted; fu_ready=0 provides backpressure.
- flush=1 (rising edge), priority over capture and broadcast:
  - hv←0, rr←0, cdb_valid←0, cdb_tag←INVALID_TAG, done←0.
  - fu_valid in that cycle is ignored, but fu_ready still follows the rule above.
  - err_invalid_tag is not cleared by flush.
- Reset mid-operation clears all held entries immediately; no partial broadcast survives.
- done is asserted for exactly one cycle per broadcast result.

Test Plan:
- Reset then idle (RST pulse, fu_valid=0 for 5 cycles):
  - cdb_valid=0, cdb_tag=0, done=0, fu_ready=4'b1111 throughout.
- Single result (FU2 presents tag 5, data 0xDEADBEEF for one cycle):
  - fu_ready[2]=1.
  - Two edges later: cdb_valid=1, tag=5, data=0xDEADBEEF, done=4'b0100 for exactly one cycle.
  - Then cdb_valid=0.
- Contention (all four FUs present tags 1,2,3,4 in the same cycle, then deassert):
  - Broadcasts on consecutive cycles in order tag 1,2,3,4 (rr=0).
  - done=0001,0010,0100,1000; fu_ready=0 for each port until its grant cycle.
- Round-robin fairness:
  - FU0 streams tags 1..8 every cycle; FU1 presents tag 9 once at cycle 3.
  - Tag 9 is broadcast within 2 cycles of being held.
  - FU0 results are never reordered or lost; 9 broadcasts in total.
- Back-to-back streaming (FU3 alone presents a new tag each cycle, tags 6,7,8):
  - fu_ready[3] stays 1.
  - CDB shows 6,7,8 on consecutive cycles.
- Flush and invalid tag:
  - With FU0 and FU1 holding tags 2 and 3, assert flush for one cycle: neither tag ever appears on the CDB; cdb_valid=0 the next cycle; rr=0.
  - Afterwards, FU1 presents tag 0 (INVALID_TAG): nothing is broadcast and err_invalid_tag=1 stays set until RST.
